// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
//   Shared definitions for the boundary-scan TAP controller:
//     - tap_state_t     : the 16 TAP states, 4-bit encoding
//     - IR_WIDTH        : default instruction register width
//     - EXTEST/SAMPLE/BYPASS opcodes
//     - tap_next_state(): IEEE 1149.1 next-state function on TMS
// -----------------------------------------------------------------------------
package jtag_pkg;

    localparam int IR_WIDTH = 4;

    localparam logic [3:0] EXTEST = 4'b0000;
    localparam logic [3:0] SAMPLE = 4'b0010;
    localparam logic [3:0] BYPASS = 4'b1111;

    typedef enum logic [3:0] {
        TLR     = 4'h0,
        RTI     = 4'h1,
        SelDR   = 4'h2,
        CapDR   = 4'h3,
        ShDR    = 4'h4,
        Ex1DR   = 4'h5,
        PauseDR = 4'h6,
        Ex2DR   = 4'h7,
        UpdDR   = 4'h8,
        SelIR   = 4'h9,
        CapIR   = 4'hA,
        ShIR    = 4'hB,
        Ex1IR   = 4'hC,
        PauseIR = 4'hD,
        Ex2IR   = 4'hE,
        UpdIR   = 4'hF
    } tap_state_t;

    // Standard TAP transition graph. Every state is at most five TMS=1
    // edges away from TLR, which gives the guaranteed reset-by-TMS.
    function automatic tap_state_t tap_next_state(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR   : RTI;
            RTI:     n = tms ? SelDR : RTI;
            SelDR:   n = tms ? SelIR : CapDR;
            CapDR:   n = tms ? Ex1DR : ShDR;
            ShDR:    n = tms ? Ex1DR : ShDR;
            Ex1DR:   n = tms ? UpdDR : PauseDR;
            PauseDR: n = tms ? Ex2DR : PauseDR;
            Ex2DR:   n = tms ? UpdDR : ShDR;
            UpdDR:   n = tms ? SelDR : RTI;
            SelIR:   n = tms ? TLR   : CapIR;
            CapIR:   n = tms ? Ex1IR : ShIR;
            ShIR:    n = tms ? Ex1IR : ShIR;
            Ex1IR:   n = tms ? UpdIR : PauseIR;
            PauseIR: n = tms ? Ex2IR : PauseIR;
            Ex2IR:   n = tms ? UpdIR : ShIR;
            UpdIR:   n = tms ? SelDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller_if
//   Control/data bundle between the TAP controller and the boundary-scan chain.
//     chain_tdi : serial data into the chain (TAP -> chain)
//     chain_tdo : serial data out of the chain (chain -> TAP)
//     ShiftDR   : shift (1) / capture (0) select for the chain cells
//     ClockDR   : gated TCK for the capture/shift flops
//     UpdateDR  : gated pulse for the update latches
//     Mode      : chain output-mux select (1 = drive pins from update latches)
//   master = TAP controller side, slave = boundary-scan chain side.
// -----------------------------------------------------------------------------
interface jtag_tap_controller_if;

    logic chain_tdi;
    logic chain_tdo;
    logic ShiftDR;
    logic ClockDR;
    logic UpdateDR;
    logic Mode;

    modport master (
        output chain_tdi,
        output ShiftDR,
        output ClockDR,
        output UpdateDR,
        output Mode,
        input  chain_tdo
    );

    modport slave (
        input  chain_tdi,
        input  ShiftDR,
        input  ClockDR,
        input  UpdateDR,
        input  Mode,
        output chain_tdo
    );

endinterface

// File: rtl/tap_fsm.sv
// -----------------------------------------------------------------------------
// tap_fsm
//   16-state TAP state machine. State advances on TCK rising according to TMS;
//   TRST_N low forces Test-Logic-Reset asynchronously.
//   Ports:
//     TCK    in  : test clock
//     TRST_N in  : asynchronous active-low reset
//     TMS    in  : mode select, sampled on TCK rising
//     state  out : current TAP state
// -----------------------------------------------------------------------------
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        state_d = tap_next_state(state_q, TMS);
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
//   TAP controller driving a ripple-adder boundary-scan chain. Owns the
//   instruction register, the 1-bit bypass register, the DR control strobes
//   and the TDO multiplexer.
//   Ports:
//     TCK         in  : test clock (both edges used)
//     TRST_N      in  : asynchronous active-low reset
//     TMS         in  : mode select, sampled on TCK rising
//     TDI         in  : serial data in, sampled on TCK rising
//     TDO         out : serial data out, changes on TCK falling
//     TDO_en      out : high while in Shift-DR or Shift-IR
//     chain       if  : boundary-scan chain bundle (master side)
//     tap_state   out : current TAP state (observation)
//     instruction out : active instruction (observation)
//   Rising-edge domain : TAP state, ir_shift, bypass.
//   Falling-edge domain: instruction, TDO, TDO_en, ShiftDR, clk_en, upd_en.
// -----------------------------------------------------------------------------
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = jtag_pkg::IR_WIDTH
) (
    input  logic                  TCK,
    input  logic                  TRST_N,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_en,
    jtag_tap_controller_if.master chain,
    output tap_state_t            tap_state,
    output logic [IR_WIDTH-1:0]   instruction
);

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(EXTEST);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(SAMPLE);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
    // Fixed "01" capture pattern lets a host verify IR length and integrity.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    tap_state_t state;

    tap_fsm u_tap_fsm (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .TMS    (TMS),
        .state  (state)
    );

    // ------------------------------------------------------------------
    // Rising-edge registers: instruction shift register and bypass bit
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_shift_d;
    logic [IR_WIDTH-1:0] ir_shifted;
    logic                bypass_q;
    logic                bypass_d;

    // Right shift: TDI enters at the MSB, bit 0 leaves on TDO.
    assign ir_shifted[IR_WIDTH-1] = TDI;
    for (genvar gi = 0; gi < IR_WIDTH - 1; gi++) begin : g_ir_shift
        assign ir_shifted[gi] = ir_shift_q[gi+1];
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        case (state)
            TLR: begin
                ir_shift_d = '0;
                bypass_d   = 1'b0;
            end
            CapIR:   ir_shift_d = IR_CAPTURE;
            ShIR:    ir_shift_d = ir_shifted;
            CapDR:   bypass_d   = 1'b0;
            ShDR:    bypass_d   = TDI;
            default: ;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
        end
    end

    // ------------------------------------------------------------------
    // Falling-edge registers: instruction, TDO path and DR strobes
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] instruction_q;
    logic [IR_WIDTH-1:0] instruction_d;
    logic                tdo_q;
    logic                tdo_d;
    logic                tdo_en_q;
    logic                tdo_en_d;
    logic                shift_dr_q;
    logic                shift_dr_d;
    logic                clk_en_q;
    logic                clk_en_d;
    logic                upd_en_q;
    logic                upd_en_d;
    logic                chain_sel;
    logic                ir_known;

    assign chain_sel = (instruction_q == OP_EXTEST) || (instruction_q == OP_SAMPLE);
    assign ir_known  = (ir_shift_q == OP_EXTEST) || (ir_shift_q == OP_SAMPLE) ||
                       (ir_shift_q == OP_BYPASS);

    always_comb begin
        instruction_d = instruction_q;
        tdo_d         = 1'b0;
        tdo_en_d      = 1'b0;
        shift_dr_d    = 1'b0;
        clk_en_d      = 1'b0;
        upd_en_d      = 1'b0;

        // Unknown opcodes are normalised to BYPASS when they are applied,
        // so the active instruction is always one of the three decoded ones.
        if (state == TLR) begin
            instruction_d = OP_BYPASS;
        end else if (state == UpdIR) begin
            instruction_d = ir_known ? ir_shift_q : OP_BYPASS;
        end

        case (state)
            ShIR: begin
                tdo_d    = ir_shift_q[0];
                tdo_en_d = 1'b1;
            end
            ShDR: begin
                tdo_d      = chain_sel ? chain.chain_tdo : bypass_q;
                tdo_en_d   = 1'b1;
                shift_dr_d = 1'b1;
            end
            default: ;
        endcase

        // Enables are computed from the state that the next rising edge
        // will act on, so ClockDR covers exactly the capture and shift edges.
        clk_en_d = ((state == CapDR) || (state == ShDR)) && chain_sel;
        upd_en_d = (state == UpdDR) && chain_sel;
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            instruction_q <= OP_BYPASS;
            tdo_q         <= 1'b0;
            tdo_en_q      <= 1'b0;
            shift_dr_q    <= 1'b0;
            clk_en_q      <= 1'b0;
            upd_en_q      <= 1'b0;
        end else begin
            instruction_q <= instruction_d;
            tdo_q         <= tdo_d;
            tdo_en_q      <= tdo_en_d;
            shift_dr_q    <= shift_dr_d;
            clk_en_q      <= clk_en_d;
            upd_en_q      <= upd_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // clk_en only changes while TCK is low, so the AND gate cannot clip a
    // high phase. UpdateDR occupies the low half of TCK in Update-DR.
    assign chain.ClockDR   = TCK & clk_en_q;
    assign chain.UpdateDR  = ~TCK & upd_en_q;
    assign chain.ShiftDR   = shift_dr_q;
    assign chain.Mode      = (instruction_q == OP_EXTEST);
    assign chain.chain_tdi = TDI;

    assign TDO         = tdo_q;
    assign TDO_en      = tdo_en_q;
    assign tap_state   = state;
    assign instruction = instruction_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_controller
//   Directed scenarios followed by a random TMS/TDI walk, all checked against
//   a behavioural model of the TAP kept in this bench.
// -----------------------------------------------------------------------------
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    logic       TCK    = 1'b0;
    logic       TRST_N = 1'b1;
    logic       TMS    = 1'b1;
    logic       TDI    = 1'b0;
    logic       TDO;
    logic       TDO_en;
    tap_state_t tap_state;
    logic [3:0] instruction;

    jtag_tap_controller_if chain_if ();

    jtag_tap_controller dut (
        .TCK         (TCK),
        .TRST_N      (TRST_N),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO         (TDO),
        .TDO_en      (TDO_en),
        .chain       (chain_if),
        .tap_state   (tap_state),
        .instruction (instruction)
    );

    always #10 TCK = ~TCK;

    int checks = 0;
    int errors = 0;

    // Pulse counters sampled mid-phase.
    int clk_pulses   = 0;
    int upd_pulses   = 0;
    int shift_cycles = 0;

    always @(posedge TCK) begin
        #1;
        if (chain_if.ClockDR === 1'b1) clk_pulses <= clk_pulses + 1;
    end

    always @(negedge TCK) begin
        #1;
        if (chain_if.UpdateDR === 1'b1) upd_pulses <= upd_pulses + 1;
        if (chain_if.ShiftDR === 1'b1) shift_cycles <= shift_cycles + 1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    tap_state_t nxt0 [16];
    tap_state_t nxt1 [16];
    tap_state_t m_st;
    logic [3:0] m_ir;
    logic [3:0] m_instr;
    logic       m_byp;
    logic       m_tdo;

    function automatic void set_arc(input tap_state_t s, input tap_state_t n0, input tap_state_t n1);
        nxt0[int'(s)] = n0;
        nxt1[int'(s)] = n1;
    endfunction

    function automatic void init_table();
        set_arc(TLR,     RTI,     TLR);
        set_arc(RTI,     RTI,     SelDR);
        set_arc(SelDR,   CapDR,   SelIR);
        set_arc(CapDR,   ShDR,    Ex1DR);
        set_arc(ShDR,    ShDR,    Ex1DR);
        set_arc(Ex1DR,   PauseDR, UpdDR);
        set_arc(PauseDR, PauseDR, Ex2DR);
        set_arc(Ex2DR,   ShDR,    UpdDR);
        set_arc(UpdDR,   RTI,     SelDR);
        set_arc(SelIR,   CapIR,   TLR);
        set_arc(CapIR,   ShIR,    Ex1IR);
        set_arc(ShIR,    ShIR,    Ex1IR);
        set_arc(Ex1IR,   PauseIR, UpdIR);
        set_arc(PauseIR, PauseIR, Ex2IR);
        set_arc(Ex2IR,   ShIR,    UpdIR);
        set_arc(UpdIR,   RTI,     SelDR);
    endfunction

    function automatic void model_reset();
        m_st    = TLR;
        m_ir    = 4'h0;
        m_instr = 4'hF;
        m_byp   = 1'b0;
        m_tdo   = 1'b0;
    endfunction

    function automatic logic model_sel();
        return (m_instr == 4'b0000) || (m_instr == 4'b0010);
    endfunction

    function automatic void model_rise(input logic tms, input logic tdi);
        if (m_st == TLR)   begin m_ir = 4'h0; m_byp = 1'b0; end
        if (m_st == CapIR) m_ir = 4'b0001;
        if (m_st == ShIR)  m_ir = {tdi, m_ir[3:1]};
        if (m_st == CapDR) m_byp = 1'b0;
        if (m_st == ShDR)  m_byp = tdi;
        m_st = tms ? nxt1[int'(m_st)] : nxt0[int'(m_st)];
    endfunction

    function automatic void model_fall(input logic ctdo);
        if (m_st == TLR) m_instr = 4'hF;
        if (m_st == UpdIR) begin
            if (m_ir == 4'b0000 || m_ir == 4'b0010 || m_ir == 4'b1111) m_instr = m_ir;
            else m_instr = 4'hF;
        end
        if (m_st == ShIR)      m_tdo = m_ir[0];
        else if (m_st == ShDR) m_tdo = model_sel() ? ctdo : m_byp;
        else                   m_tdo = 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: inputs applied in the low phase, outputs checked
    // 2 time units after the falling edge.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #2;
        model_rise(tms, tdi);
        chain_if.chain_tdo = 1'($urandom_range(0, 1));
        @(negedge TCK);
        #2;
        model_fall(chain_if.chain_tdo);
        chk("state",     32'(tap_state),          32'(m_st));
        chk("instr",     32'(instruction),        32'(m_instr));
        chk("mode",      32'(chain_if.Mode),      32'(m_instr == 4'b0000));
        chk("tdo",       32'(TDO),                32'(m_tdo));
        chk("tdo_en",    32'(TDO_en),             32'((m_st == ShIR) || (m_st == ShDR)));
        chk("shiftdr",   32'(chain_if.ShiftDR),   32'(m_st == ShDR));
        chk("updatedr",  32'(chain_if.UpdateDR),  32'((m_st == UpdDR) && model_sel()));
        chk("clockdr_lo", 32'(chain_if.ClockDR),  32'(0));
        chk("chain_tdi", 32'(chain_if.chain_tdi), 32'(tdi));
    endtask

    // From RTI: load an instruction and return the four captured TDO bits.
    task automatic shift_ir(input logic [3:0] val, output logic [3:0] reads);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            reads[i] = TDO;
            step(i == 3, val[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: capture, shift n bits, update, back to RTI.
    task automatic shift_dr(input int n, input logic [31:0] bits, input bit chain_path,
                            output logic [31:0] reads);
        reads = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            reads[i] = TDO;
            if (chain_path) chk("chain_tdo_path", 32'(TDO), 32'(chain_if.chain_tdo));
            step(i == n - 1, bits[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [3:0]  ir_reads;
    logic [31:0] dr_reads;
    int          c0, u0, s0;

    initial begin
        #400_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_table();
        model_reset();
        chain_if.chain_tdo = 1'b0;

        // Reset: TRST_N low for 2 TCK, then five TMS=1 cycles.
        #1 TRST_N = 1'b0;
        repeat (2) @(negedge TCK);
        #2;
        chk("rst_tdo",    32'(TDO),               32'(0));
        chk("rst_tdo_en", 32'(TDO_en),            32'(0));
        chk("rst_mode",   32'(chain_if.Mode),     32'(0));
        chk("rst_shift",  32'(chain_if.ShiftDR),  32'(0));
        chk("rst_upd",    32'(chain_if.UpdateDR), 32'(0));
        chk("rst_state",  32'(tap_state),         32'(TLR));
        TRST_N = 1'b1;
        repeat (5) step(1'b1, 1'b0);
        chk("tlr_instr", 32'(instruction), 32'(BYPASS));
        step(1'b0, 1'b0);

        // IR capture and load of EXTEST.
        shift_ir(4'b0000, ir_reads);
        chk("ir_capture", 32'(ir_reads), 32'(4'b0001));
        chk("ir_extest",  32'(instruction), 32'(EXTEST));
        chk("ir_mode",    32'(chain_if.Mode), 32'(1));

        // Bypass: TDI 1,0,1,1 -> TDO 0,1,0,1.
        shift_ir(4'b1111, ir_reads);
        c0 = clk_pulses; u0 = upd_pulses;
        shift_dr(4, 32'b1101, 1'b0, dr_reads);
        chk("bypass_tdo", 32'(dr_reads[3:0]), 32'(4'b1010));
        chk("bypass_clk", 32'(clk_pulses - c0), 32'(0));
        chk("bypass_upd", 32'(upd_pulses - u0), 32'(0));

        // EXTEST: capture + 17 shifts.
        shift_ir(4'b0000, ir_reads);
        c0 = clk_pulses; u0 = upd_pulses; s0 = shift_cycles;
        shift_dr(17, $urandom, 1'b1, dr_reads);
        chk("extest_clk",   32'(clk_pulses - c0),   32'(18));
        chk("extest_shift", 32'(shift_cycles - s0), 32'(17));
        chk("extest_upd",   32'(upd_pulses - u0),   32'(1));

        // SAMPLE: chain selected, Mode low.
        shift_ir(4'b0010, ir_reads);
        chk("sample_mode", 32'(chain_if.Mode), 32'(0));
        c0 = clk_pulses; u0 = upd_pulses;
        shift_dr(5, $urandom, 1'b1, dr_reads);
        chk("sample_clk", 32'(clk_pulses - c0), 32'(6));
        chk("sample_upd", 32'(upd_pulses - u0), 32'(1));

        // Unknown opcode decodes as BYPASS.
        shift_ir(4'b0101, ir_reads);
        chk("unknown_op", 32'(instruction), 32'(BYPASS));

        // Pause in the middle of an EXTEST shift.
        shift_ir(4'b0000, ir_reads);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        c0 = clk_pulses;
        repeat (3) begin
            step(1'b0, 1'b0);
            chk("pause_tdo_en", 32'(TDO_en), 32'(0));
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pause_clk", 32'(clk_pulses - c0), 32'(0));
        chk("resume_tdo_en", 32'(TDO_en), 32'(1));
        c0 = clk_pulses;
        step(1'b0, 1'b1);
        chk("resume_clk", 32'(clk_pulses - c0), 32'(1));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Asynchronous reset during Shift-DR with EXTEST loaded (high phase).
        shift_ir(4'b0000, ir_reads);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        TMS = 1'b0;
        @(posedge TCK);
        #4;
        TRST_N = 1'b0;
        #1;
        chk("mrst_mode",    32'(chain_if.Mode),    32'(0));
        chk("mrst_shift",   32'(chain_if.ShiftDR), 32'(0));
        chk("mrst_tdo_en",  32'(TDO_en),           32'(0));
        chk("mrst_clockdr", 32'(chain_if.ClockDR), 32'(0));
        chk("mrst_tdo",     32'(TDO),              32'(0));
        chk("mrst_instr",   32'(instruction),      32'(BYPASS));
        @(negedge TCK);
        #2;
        TRST_N = 1'b1;
        model_reset();
        step(1'b0, 1'b0);
        shift_ir(4'b1111, ir_reads);
        chk("mrst_capture", 32'(ir_reads), 32'(4'b0001));

        // Random walk; every 40 steps, five TMS=1 edges must reach TLR.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)));
            if (k % 40 == 39) begin
                repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
                chk("five_tms_tlr", 32'(tap_state), 32'(TLR));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
